// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank write path: bank geometry,
// write-port state encoding and the register address decoder.
package regbank_pkg;

  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } wr_state_e;

  function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_AW-1:0] addr);
    logic [NUM_REGS-1:0] dec;
    dec       = '0;
    dec[addr] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Requester handshake plus bank write port of the shared register-bank writer.
// The slave modport is the arbiter; the master modport is its environment.
interface regbank_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 5,
  parameter int DW      = 32
);
  import regbank_pkg::*;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic                  RegWrite;
  logic [AW-1:0]         write_register;
  logic [DW-1:0]         write_data;
  logic [1:0]            grant_id;
  logic [NUM_REGS-1:0]   pending_mask;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, RegWrite, write_register, write_data, grant_id, pending_mask
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, RegWrite, write_register, write_data, grant_id, pending_mask
  );
endinterface

// File: rtl/regbank_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves one past the winner on every grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [1:0]         grant_idx_o
);

  localparam int PW = 2;

  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic               found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    ptr_d     = ptr_q;
    found     = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] && (i == (int'(ptr_q) + off) % NUM_REQ)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = PW'(i);
          ptr_d     = PW'((i + 1) % NUM_REQ);
        end
      end
    end
    // A disabled arbiter grants nothing and must not advance the pointer.
    if (!en_i) begin
      grant = '0;
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign grant_o     = grant;
  assign grant_idx_o = grant_idx;

endmodule

// File: rtl/regbank_write_arbiter.sv
// Shares the register bank's single write port between NUM_REQ write-back
// sources; drives the bank from registers and publishes a pending-write mask.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = 5,
  parameter int DW      = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  regbank_write_arbiter_if.slave  bus
);

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("regbank_write_arbiter: NUM_REQ must be in 2..4");
  end
  if (AW != REG_AW) begin : g_bad_aw
    $error("regbank_write_arbiter: AW must match the register bank address width");
  end

  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_idx;
  logic               accept;
  logic [AW-1:0]      acc_addr;
  logic [DW-1:0]      acc_data;

  wr_state_e          state_q;
  logic               regwrite_q;
  logic [AW-1:0]      wreg_q;
  logic [DW-1:0]      wdata_q;
  logic [1:0]         gid_q;
  logic [NUM_REGS-1:0] pending;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk         (clock),
    .rst_n       (reset_n),
    .en_i        (reset_n),
    .req_i       (bus.req_valid),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign accept = |grant;

  always_comb begin
    acc_addr = '0;
    acc_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        acc_addr = bus.req_addr[i*AW +: AW];
        acc_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  // Output stage: a register-0 write is accepted and tracked but never enabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      gid_q      <= '0;
    end else begin
      if (accept) begin
        regwrite_q <= (acc_addr != AW'(REG_ZERO));
        wreg_q     <= acc_addr;
        wdata_q    <= acc_data;
        gid_q      <= grant_idx;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!accept) begin
            state_q    <= ST_IDLE;
            regwrite_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Requests are invisible to hazard logic while the block is held in reset.
  always_comb begin
    pending = '0;
    if (reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i]) pending = pending | onehot_reg(REG_AW'(bus.req_addr[i*AW +: AW]));
      end
    end
    if (regwrite_q) pending = pending | onehot_reg(REG_AW'(wreg_q));
    pending[0] = 1'b0;
  end

  assign bus.req_ready      = grant;
  assign bus.RegWrite       = regwrite_q;
  assign bus.write_register = wreg_q;
  assign bus.write_data     = wdata_q;
  assign bus.grant_id       = gid_q;
  assign bus.pending_mask   = pending;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter with a negedge-committing bank model.
module tb_regbank_write_arbiter;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  regbank_write_arbiter_if #(.NUM_REQ(2), .AW(5), .DW(32)) bus ();

  regbank_write_arbiter #(.NUM_REQ(2), .AW(5), .DW(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  logic [31:0] bank [32] = '{default: 32'h0};

  always @(negedge clock) begin
    if (bus.RegWrite) bank[bus.write_register] <= bus.write_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr[i*5 +: 5]  = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.req_valid = 2'b11;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    set_req(0, 5'd5, 32'h0000_0050);
    set_req(1, 5'd6, 32'h0000_0060);

    // Reset held with both requesters valid
    #12;
    check("rst_regwrite", 32'(bus.RegWrite), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_pending", bus.pending_mask, 32'h0);
    check("rst_wreg", 32'(bus.write_register), 32'h0);
    check("rst_gid", 32'(bus.grant_id), 32'h0);

    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rel_ready", 32'(bus.req_ready), 32'h1);
    check("rel_pending", bus.pending_mask, 32'h0000_0060);

    tick();
    check("first_regwrite", 32'(bus.RegWrite), 32'h1);
    check("first_wreg", 32'(bus.write_register), 32'd5);
    check("first_gid", 32'(bus.grant_id), 32'd0);
    check("first_ready", 32'(bus.req_ready), 32'h2);
    set_req(0, 5'd3, 32'hAAAA_0000);

    tick();
    check("second_gid", 32'(bus.grant_id), 32'd1);
    check("second_wreg", 32'(bus.write_register), 32'd6);
    check("second_ready", 32'(bus.req_ready), 32'h1);
    set_req(1, 5'd4, 32'h5555_FFFF);

    // Fairness: alternation with RegWrite held high
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fair_regwrite", 32'(bus.RegWrite), 32'h1);
      check("fair_gid", 32'(bus.grant_id), (k % 2 == 0) ? 32'd0 : 32'd1);
      check("fair_wreg", 32'(bus.write_register), (k % 2 == 0) ? 32'd3 : 32'd4);
      check("fair_wdata", bus.write_data, (k % 2 == 0) ? 32'hAAAA_0000 : 32'h5555_FFFF);
    end
    bus.req_valid = 2'b00;
    tick();
    check("fair_idle", 32'(bus.RegWrite), 32'h0);
    @(negedge clock);
    #1;
    check("bank_r3", bank[3], 32'hAAAA_0000);
    check("bank_r4", bank[4], 32'h5555_FFFF);
    check("bank_r5", bank[5], 32'h0000_0050);
    check("bank_r6", bank[6], 32'h0000_0060);

    // Register 0 from requester 1
    set_req(1, 5'd0, 32'hDEAD_BEEF);
    bus.req_valid = 2'b10;
    #1;
    check("zero_ready", 32'(bus.req_ready), 32'h2);
    check("zero_pending_req", bus.pending_mask, 32'h0);
    tick();
    check("zero_wreg", 32'(bus.write_register), 32'd0);
    check("zero_regwrite", 32'(bus.RegWrite), 32'h0);
    check("zero_gid", 32'(bus.grant_id), 32'd1);
    check("zero_wdata", bus.write_data, 32'hDEAD_BEEF);
    check("zero_pending", bus.pending_mask, 32'h0);
    bus.req_valid = 2'b00;
    @(negedge clock);
    #1;
    check("bank_r0", bank[0], 32'h0);

    // Move pointer to 1, then collide on register 7
    set_req(0, 5'd10, 32'h0000_010A);
    bus.req_valid = 2'b01;
    tick();
    set_req(0, 5'd7, 32'h0000_0011);
    set_req(1, 5'd7, 32'h0000_0022);
    bus.req_valid = 2'b11;
    #1;
    check("coll_ready", 32'(bus.req_ready), 32'h2);
    check("coll_pending0", bus.pending_mask, 32'h0000_0480);
    tick();
    check("coll_gid1", 32'(bus.grant_id), 32'd1);
    check("coll_wdata1", bus.write_data, 32'h0000_0022);
    check("coll_ready2", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b01;
    #1;
    check("coll_pending1", bus.pending_mask, 32'h0000_0080);
    tick();
    check("coll_gid0", 32'(bus.grant_id), 32'd0);
    check("coll_wdata0", bus.write_data, 32'h0000_0011);
    bus.req_valid = 2'b00;
    #1;
    check("coll_pending2", bus.pending_mask, 32'h0000_0080);
    tick();
    check("coll_idle", 32'(bus.RegWrite), 32'h0);
    check("coll_pending3", bus.pending_mask, 32'h0);
    @(negedge clock);
    #1;
    check("bank_r7", bank[7], 32'h0000_0011);

    // Back-to-back from requester 0, then idle
    for (int k = 1; k <= 3; k++) begin
      set_req(0, 5'(k), 32'h0000_0100 + 32'(k));
      bus.req_valid = 2'b01;
      tick();
      check("b2b_regwrite", 32'(bus.RegWrite), 32'h1);
      check("b2b_wreg", 32'(bus.write_register), 32'(k));
    end
    bus.req_valid = 2'b00;
    tick();
    check("b2b_idle", 32'(bus.RegWrite), 32'h0);
    @(negedge clock);
    #1;
    check("bank_r1", bank[1], 32'h0000_0101);
    check("bank_r2", bank[2], 32'h0000_0102);

    // Asynchronous reset while a write is on the port
    set_req(0, 5'd9, 32'h0000_0099);
    bus.req_valid = 2'b01;
    tick();
    check("mid_regwrite", 32'(bus.RegWrite), 32'h1);
    check("mid_wreg", 32'(bus.write_register), 32'd9);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_abort", 32'(bus.RegWrite), 32'h0);
    check("mid_ready", 32'(bus.req_ready), 32'h0);
    check("mid_pending", bus.pending_mask, 32'h0);
    @(negedge clock);
    #1;
    check("bank_r9", bank[9], 32'h0);
    bus.req_valid = 2'b00;
    reset_n = 1'b1;
    #10;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
